// File: rtl/rr_mux_pkg.sv
// Shared helpers for round-robin arbiters: select-width derivation and a
// rotate-and-priority-encode search over a request vector.
package rr_mux_pkg;

  // Widest request vector the shared search function handles
  localparam int RR_MAX_N = 32;

  // Index width for an N-entry arbiter (at least one bit)
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Returns {found, index}: the first set bit of req[n-1:0] when scanning
  // ptr, ptr+1, ... n-1, 0, ... ptr-1. Scanning offsets from high to low lets
  // the smallest offset from ptr overwrite any later candidate.
  function automatic logic [5:0] rr_first(input logic [RR_MAX_N-1:0] req,
                                          input logic [5:0]          n,
                                          input logic [4:0]          ptr);
    logic [5:0] res;
    logic [5:0] c;
    res = '0;
    for (int k = RR_MAX_N - 1; k >= 0; k--) begin
      c = {1'b0, ptr} + 6'(k);
      if (c >= n) c = c - n;
      if ((6'(k) < n) && req[c[4:0]]) res = {1'b1, c[4:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_mux_reg_arb.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr and reports it both one-hot and as an index.
module rr_arb
  import rr_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] gidx,
  output logic            any
);

  logic [RR_MAX_N-1:0] req_ext;
  logic [5:0]          pick;

  // Rotating priority search, then expand the winning index to one-hot
  always_comb begin
    req_ext = RR_MAX_N'(req);
    pick    = rr_first(req_ext, 6'(N), 5'(ptr));
    any     = pick[5];
    gidx    = SELW'(pick[4:0]);
    grant   = '0;
    if (pick[5]) grant[gidx] = 1'b1;
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel round-robin arbitrating mux with a registered valid/ready output.
// Optional packet mode: define RR_MUX_LAST_EN to add in_last/out_last and hold
// the grant on one channel until its last beat has been accepted.
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef RR_MUX_LAST_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
`ifdef RR_MUX_LAST_EN
  output logic               out_last,
`endif
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load;
  logic             accept;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  gidx;
  logic             any;
  logic [SELW-1:0]  gidx_next;
  logic [WIDTH-1:0] sel_data;

`ifdef RR_MUX_LAST_EN
  logic             lock_q, lock_d;
  logic             out_last_q, out_last_d;

  // While a packet is open only the locked channel (held in out_sel) may win
  always_comb begin
    req = in_valid;
    if (lock_q) req = in_valid & (N'(1) << out_sel_q);
  end
`else
  // Every beat is arbitrated independently
  always_comb begin
    req = in_valid;
  end
`endif

  rr_arb #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  // Handshake: the output register can take a beat when empty or draining;
  // in_ready is forced low while reset is asserted
  always_comb begin
    load      = !out_valid_q || out_ready;
    accept    = load && any;
    in_ready  = (load && reset_n) ? grant : '0;
    gidx_next = (gidx == SELW'(N - 1)) ? '0 : gidx + 1'b1;
  end

  // One-hot AND-OR data select of the granted channel
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Next state of the output register and round-robin pointer
  always_comb begin
    out_valid_d = load ? any : out_valid_q;
    out_data_d  = accept ? sel_data : out_data_q;
    out_sel_d   = accept ? gidx : out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_LAST_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_last_d = in_last[gidx];
      lock_d     = !in_last[gidx];
      if (in_last[gidx]) ptr_d = gidx_next;
    end
`else
    if (accept) ptr_d = gidx_next;
`endif
  end

  // State registers; reset empties the output stage immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_MUX_LAST_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_LAST_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef RR_MUX_LAST_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg (N=4, WIDTH=8). Packet-mode rows run when
// RR_MUX_LAST_EN is defined for both the design and the bench.
module tb_rr_mux_reg;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;
`ifdef RR_MUX_LAST_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_MUX_LAST_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
`ifdef RR_MUX_LAST_EN
    .out_last  (out_last),
`endif
    .out_ready (out_ready)
  );

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  last;
    logic          r;
    logic [N-1:0]  exp_rdy;
    logic          exp_ov;
    logic [SW-1:0] exp_sel;
    logic [W-1:0]  exp_data;
    logic          exp_last;
  } vec_t;

  typedef struct packed {
    logic          last;
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } beat_t;

  vec_t  tq[$];
  beat_t sbq[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Reference model state
  logic  m_valid = 1'b0;
  int    m_ptr   = 0;
  logic  m_lock  = 1'b0;
  int    m_lockch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_ptr    = 0;
    m_lock   = 1'b0;
    m_lockch = 0;
    sbq.delete();
  endtask

  // Drive one cycle (called at posedge+1), check against model at the
  // falling edge, advance the model, return at the next posedge+1.
  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] last,
                       input logic r, output logic [N-1:0] rdy);
    int           g;
    logic [N-1:0] er;
    beat_t        b;
    in_valid  = v;
    out_ready = r;
`ifdef RR_MUX_LAST_EN
    in_last   = last;
`endif
    #4;
    check("sb_out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sbq.size() == 0) begin
        check("sb_queue_empty", 32'(0), 32'(1));
      end else begin
        check("sb_out_data", 32'(out_data), 32'(sbq[0].data));
        check("sb_out_sel", 32'(out_sel), 32'(sbq[0].sel));
`ifdef RR_MUX_LAST_EN
        check("sb_out_last", 32'(out_last), 32'(sbq[0].last));
`endif
        if (r) void'(sbq.pop_front());
      end
    end
    g = -1;
    for (int k = N - 1; k >= 0; k--) begin
      int c;
      c = (m_ptr + k) % N;
      if (v[c] && (!m_lock || c == m_lockch)) g = c;
    end
    er = '0;
    if ((!m_valid || r) && g >= 0) er[g] = 1'b1;
    rdy = in_ready;
    check("sb_in_ready", 32'(in_ready), 32'(er));
    if (!m_valid || r) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        b.last = last[g];
        b.sel  = SW'(g);
        b.data = 8'(8'hA0 + g);
        sbq.push_back(b);
`ifdef RR_MUX_LAST_EN
        if (last[g]) begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock   = 1'b1;
          m_lockch = g;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Apply every row of tq and compare against its hand-derived expectations
  task automatic run_table(input string tag);
    logic [N-1:0] rdy;
    for (int i = 0; i < tq.size(); i++) begin
      apply(tq[i].v, tq[i].last, tq[i].r, rdy);
      check({tag, "_in_ready"},  32'(rdy),       32'(tq[i].exp_rdy));
      check({tag, "_out_valid"}, 32'(out_valid), 32'(tq[i].exp_ov));
      check({tag, "_out_sel"},   32'(out_sel),   32'(tq[i].exp_sel));
      check({tag, "_out_data"},  32'(out_data),  32'(tq[i].exp_data));
`ifdef RR_MUX_LAST_EN
      check({tag, "_out_last"},  32'(out_last),  32'(tq[i].exp_last));
`endif
    end
    tq.delete();
  endtask

  initial begin
    logic [N-1:0] rdy;
    in_data   = 32'hA3A2A1A0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
`ifdef RR_MUX_LAST_EN
    in_last   = 4'hF;
`endif
    reset_n   = 1'b0;

    // Reset with requests active: output empty, no channel accepted
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_sel",   32'(out_sel),   32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_in_ready",  32'(in_ready),  32'(0));
    in_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // All four requesting: 0,1,2,3,0
    tq.push_back('{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1});
    tq.push_back('{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1});
    tq.push_back('{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1});
    tq.push_back('{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1});
    tq.push_back('{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1});
    // Single requester ch2 wins every cycle
    for (int i = 0; i < 5; i++)
      tq.push_back('{4'b0100, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1});
    // Backpressure for three cycles, then release
    for (int i = 0; i < 3; i++)
      tq.push_back('{4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 1'b1});
    tq.push_back('{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1});
    // Wrap: grant ch2 sets ptr=3, then requests 1001 -> ch3, ch0; then idle
    tq.push_back('{4'b0100, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1});
    tq.push_back('{4'b1001, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1});
    tq.push_back('{4'b1001, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1});
    tq.push_back('{4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0, 1'b1});
    run_table("rr");

    // Reset asserted mid-transfer drops the held beat at once
    apply(4'hF, 4'hF, 1'b1, rdy);
    apply(4'hF, 4'hF, 1'b0, rdy);
    check("mid_pre_valid", 32'(out_valid), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_out_sel",   32'(out_sel),   32'(0));
    check("mid_rst_out_data",  32'(out_data),  32'(0));
    check("mid_rst_in_ready",  32'(in_ready),  32'(0));
    in_valid = '0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef RR_MUX_LAST_EN
    // Packet mode: ch0 single beat moves ptr to 1, then ch1 3-beat packet
    // (with an idle gap while locked) ahead of ch2 and ch0
    tq.push_back('{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1});
    tq.push_back('{4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b0});
    tq.push_back('{4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b0});
    tq.push_back('{4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd1, 8'hA1, 1'b0});
    tq.push_back('{4'b0111, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1});
    tq.push_back('{4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1});
    tq.push_back('{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1});
    run_table("pkt");
`endif

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
